// File: rtl/fpu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer_if
//
// Purpose: groups the command, unit-array and response signals of the FPU
// operation sequencer into a single bundle.
//
// Handshake rule (request and response channels alike): a transfer happens
// on a rising clk edge where both valid and ready are 1. The producer holds
// its payload stable while valid is high and ready is low. Valid never
// depends on ready.
//
// Signals:
//   req_valid / req_ready / req_op      : command channel (op 1..9 legal)
//   unit_start[8:0]                     : one-hot start strobe, bit op-1
//   unit_done[8:0]                      : per-unit done, bit op-1
//   ena[3:0]                            : output-mux select
//   out_muxed[31:0]                     : output-mux result
//   resp_valid / resp_ready             : response channel
//   resp_data[31:0] / resp_err          : response payload
//
// Modports:
//   master : the environment (command source, unit array, response sink)
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface fpu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [8:0]  unit_start;
  logic [8:0]  unit_done;
  logic [3:0]  ena;
  logic [31:0] out_muxed;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_op, unit_done, out_muxed, resp_ready,
    input  req_ready, unit_start, ena, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, unit_done, out_muxed, resp_ready,
    output req_ready, unit_start, ena, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer
//
// Purpose: single-issue sequencer between the FPU command interface and the
// arithmetic unit array plus output mux. It accepts one operation, strobes
// the selected unit for one cycle, steers the output mux, waits for the
// selected unit's done, captures the muxed result and returns it over the
// response handshake. Illegal opcodes (0, 10..15) return an error response
// without starting any unit.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : fpu_op_sequencer_if.slave (request, unit, response signals)
//   dbg_state_o  : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Parameters:
//   TIMEOUT_CYCLES : WAIT cycles allowed before a forced error response
//                    (only used when FPU_SEQ_TIMEOUT_EN is defined).
//
// Build option:
//   FPU_SEQ_TIMEOUT_EN : when defined, a watchdog counter in WAIT forces an
//                        error response after TIMEOUT_CYCLES cycles with no
//                        done from the selected unit. When undefined, WAIT
//                        lasts until the selected done arrives.
// ---------------------------------------------------------------------------
module fpu_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpu_op_sequencer_if.slave    bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [8:0]  op_onehot;
  logic        done_sel;
  logic        req_legal;
  logic        timeout_hit;

  // Opcodes 1..9 map to start/done bit op-1; anything else maps to no unit.
  function automatic logic [8:0] op_to_onehot(input logic [3:0] op);
    logic [8:0] oh;
    oh = '0;
    if (op >= 4'd1 && op <= 4'd9) begin
      oh = 9'd1 << (op - 4'd1);
    end
    return oh;
  endfunction

  assign req_legal = |op_to_onehot(bus.req_op);
  assign op_onehot = op_to_onehot(op_q);
  // Only the selected unit's done is looked at; the others are masked off.
  assign done_sel  = |(bus.unit_done & op_onehot);

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside WAIT, so it is cleared on every entry to WAIT.
  // The last permitted WAIT cycle is the one where cnt_q == TIMEOUT_CYCLES-1.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;

  // Watchdog not built: TIMEOUT_CYCLES is intentionally left without effect.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d = bus.req_op;
          if (req_legal) begin
            state_d = S_ISSUE;
          end else begin
            // Illegal opcode: straight to an error response, no unit started.
            state_d = S_RESP;
            data_d  = '0;
            err_d   = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        // Combinational units may already report done during the strobe.
        if (done_sel) begin
          data_d  = bus.out_muxed;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // A done in the same cycle as the watchdog limit takes priority.
        if (done_sel) begin
          data_d  = bus.out_muxed;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // All control outputs decode directly from the state register, so an
  // asynchronous reset returns them to their reset values at once.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.unit_start = (state_q == S_ISSUE) ? op_onehot : 9'd0;
  assign bus.ena        = (state_q == S_ISSUE || state_q == S_WAIT) ? op_q : 4'd0;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_sequencer
//
// Self-checking bench for fpu_op_sequencer. Each operation is described by
// its opcode, the done delay k (done first high in cycle N+1+k, k<0 means
// never), the result value and the number of response stall cycles. The
// expected cycle-by-cycle control outputs and the response payload follow
// from those numbers alone. Build with +define+FPU_SEQ_TIMEOUT_EN to include
// the watchdog scenarios.
// ---------------------------------------------------------------------------
module tb_fpu_op_sequencer;

  localparam int unsigned TO = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  fpu_op_sequencer_if bus ();

  fpu_op_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks;
  int n_pass;
  logic [32:0] exp_q[$];  // {resp_err, resp_data} per outstanding operation

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit is_legal(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd9);
  endfunction

  // ---------------- driver / checker ----------------
  // Called with the bench just past a negedge in an IDLE cycle (cycle N).
  task automatic run_op(input string name, input logic [3:0] op, input int k,
                        input logic [31:0] data, input int stall, input bit present_req);
    bit          legal;
    bit          to;
    int          lat;
    logic [8:0]  sel;
    logic [8:0]  exp_start;
    logic [3:0]  exp_ena;
    logic [14:0] exp_vec;
    logic [14:0] got_vec;
    legal = is_legal(op);
    sel = 9'd0;
    if (legal) sel[op - 4'd1] = 1'b1;
    to = 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
    to = legal && ((k < 0) || (k > int'(TO)));
`endif
    // Cycles from acceptance to first cycle with resp_valid high.
    if (!legal)  lat = 1;
    else if (to) lat = 2 + int'(TO);
    else         lat = 2 + k;
    exp_q.push_back((!legal || to) ? {1'b1, 32'h0} : {1'b0, data});

    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.out_muxed  = data;
    bus.unit_done  = 9'd0;
    bus.resp_ready = 1'b0;

    for (int c = 1; c <= lat + stall; c++) begin
      @(negedge clk);
      bus.req_valid  = present_req && (c < lat + stall);
      if (present_req) bus.req_op = 4'($urandom_range(1, 9));
      bus.resp_ready = (c >= lat + stall);
      bus.unit_done  = 9'($urandom) & ~sel;
      if (legal && k >= 0 && c >= 1 + k) bus.unit_done = bus.unit_done | sel;
      #1;
      exp_start = (legal && c == 1) ? sel : 9'd0;
      exp_ena   = (legal && c < lat) ? op : 4'd0;
      exp_vec   = {1'b0, exp_start, exp_ena, (c >= lat)};
      got_vec   = {bus.req_ready, bus.unit_start, bus.ena, bus.resp_valid};
      n_checks++;
      if (got_vec !== exp_vec)
        $display("FAIL %s ctrl@N+%0d {req_ready,unit_start,ena,resp_valid}: got %h expected %h",
                 name, c, got_vec, exp_vec);
      else n_pass++;
      if (c >= lat) begin
        n_checks++;
        if ({bus.resp_err, bus.resp_data} !== exp_q[0])
          $display("FAIL %s resp@N+%0d {err,data}: got %h expected %h",
                   name, c, {bus.resp_err, bus.resp_data}, exp_q[0]);
        else n_pass++;
      end
    end
    void'(exp_q.pop_front());

    // Cycle after the response handshake: back in IDLE, nothing started.
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.unit_done  = 9'd0;
    #1;
    n_checks++;
    got_vec = {bus.req_ready, bus.unit_start, bus.ena, bus.resp_valid};
    if (got_vec !== {1'b1, 9'd0, 4'd0, 1'b0})
      $display("FAIL %s idle_after_handshake: got %h expected %h",
               name, got_vec, {1'b1, 9'd0, 4'd0, 1'b0});
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 4'd0;
    bus.unit_done  = 9'd0;
    bus.out_muxed  = 32'h0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.req_ready, bus.unit_start, bus.ena, bus.resp_valid, bus.resp_err, bus.resp_data}
        !== {1'b1, 9'd0, 4'd0, 1'b0, 1'b0, 32'h0})
      $display("FAIL reset_values: got rdy=%b start=%h ena=%h rv=%b err=%b data=%h expected 1/0/0/0/0/0",
               bus.req_ready, bus.unit_start, bus.ena, bus.resp_valid, bus.resp_err, bus.resp_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_comb_op();
    run_op("sign_comb", 4'd5, 0, 32'h8000_0000, 0, 1'b0);
  endtask

  task automatic test_multicycle();
    run_op("div_wait10", 4'd3, 10, 32'h3F80_0000, 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_op("illegal_12", 4'd12, 0, 32'h1234_5678, 0, 1'b0);
    run_op("illegal_0", 4'd0, 0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("illegal_15", 4'd15, 2, 32'hA5A5_A5A5, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op("backpressure_mul", 4'd2, 3, 32'h4049_0FDB, 5, 1'b1);
    run_op("backpressure_illegal", 4'd11, 0, 32'h0, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_op("back_to_back", 4'($urandom_range(1, 9)), 0, $urandom, 0, 1'b0);
  endtask

`ifdef FPU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_op("timeout_sqrt", 4'd4, -1, 32'hDEAD_BEEF, 0, 1'b0);
    run_op("done_at_limit", 4'd6, int'(TO), 32'h0000_0001, 0, 1'b0);
    run_op("done_past_limit", 4'd1, int'(TO) + 1, 32'h0000_0002, 2, 1'b0);
  endtask
`endif

  task automatic test_random();
    int k;
    for (int i = 0; i < 24; i++) begin
`ifdef FPU_SEQ_TIMEOUT_EN
      k = int'($urandom_range(0, TO + 3)) - 1;
`else
      k = int'($urandom_range(0, 12));
`endif
      run_op("random", 4'($urandom_range(0, 15)), k, $urandom,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [14:0] got_vec;
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd9;
    bus.out_muxed = 32'hCAFE_F00D;
    bus.unit_done = 9'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.ena !== 4'd9) $display("FAIL mac_in_wait ena: got %0d expected 9", bus.ena);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.unit_start, bus.ena, bus.resp_valid, bus.resp_err, bus.resp_data}
        !== {1'b1, 9'd0, 4'd0, 1'b0, 1'b0, 32'h0})
      $display("FAIL async_reset_mid_wait: got rdy=%b start=%h ena=%h rv=%b err=%b data=%h expected 1/0/0/0/0/0",
               bus.req_ready, bus.unit_start, bus.ena, bus.resp_valid, bus.resp_err, bus.resp_data);
    else n_pass++;
    @(negedge clk);
    bus.unit_done = 9'h100;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    got_vec = {bus.req_ready, bus.unit_start, bus.ena, bus.resp_valid};
    if (got_vec !== {1'b1, 9'd0, 4'd0, 1'b0})
      $display("FAIL discarded_result_after_reset: got %h expected %h", got_vec, {1'b1, 9'd0, 4'd0, 1'b0});
    else n_pass++;
    bus.unit_done = 9'd0;
    run_op("mac_after_reset", 4'd9, 4, 32'h4120_0000, 1, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_comb_op();
    test_multicycle();
    test_illegal();
    test_backpressure();
    test_back_to_back();
`ifdef FPU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
